call_stack: RTL

- Parametrised return-address stack for the Gumnut core; successor to the fixed 12-bit × 8 PC stack.
- Adds generic width and depth, simultaneous push and pop (replace), flush, full/empty/count status, and a selectable overflow policy.
- Also adds sticky overflow/underflow error flags.
- Sits beside the PC unit: `push_i` on CALL, `pop_i` on RET; `top_o` feeds the next-PC mux.

---
 rtl/gumnut_stack_pkg.sv | 10 +
 rtl/stack_regfile.sv | 22 ++
 rtl/call_stack.sv | 78 +++++++
 3 files changed

// File: rtl/gumnut_stack_pkg.sv
// gumnut_stack_pkg: shared op encoding and width helpers for the return-address stack
package gumnut_stack_pkg;
  typedef enum logic [2:0] {STK_IDLE, STK_PUSH, STK_POP, STK_REPL, STK_FLUSH} stk_op_e;
  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/stack_regfile.sv
// stack_regfile: DEPTH x WIDTH storage, one sync write port, two async read ports, no reset
module stack_regfile #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 8,
  parameter int PW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [PW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [PW-1:0]    raddr0_i,
  input  logic [PW-1:0]    raddr1_i,
  output logic [WIDTH-1:0] rdata0_o,
  output logic [WIDTH-1:0] rdata1_o
);
  logic [WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end
  assign rdata0_o = mem[raddr0_i];
  assign rdata1_o = mem[raddr1_i];
endmodule

// File: rtl/call_stack.sv
// call_stack: parametrised return-address stack with replace, flush, status and sticky error flags
module call_stack import gumnut_stack_pkg::*; #(
  parameter int WIDTH    = 12,
  parameter int DEPTH    = 8,
  parameter bit OVF_WRAP = 1'b0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cen,
  input  logic                      push_i,
  input  logic                      pop_i,
  input  logic                      flush_i,
  input  logic                      clr_err_i,
  input  logic [WIDTH-1:0]          pc_i,
  output logic [WIDTH-1:0]          top_o,
  output logic [cnt_w(DEPTH)-1:0]   count_o,
  output logic                      empty_o,
  output logic                      full_o,
  output logic                      ovf_o,
  output logic                      unf_o
);
  localparam int PW = ptr_w(DEPTH);
  localparam int CW = cnt_w(DEPTH);
  logic [PW-1:0]    wp_q, wp_d, waddr;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] top_q, top_d, rd_top, rd_next;
  logic             ovf_q, ovf_d, unf_q, unf_d, we, do_push, do_pop;
  stk_op_e          op;
  stack_regfile #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PW(PW)) u_rf (
    .clk      (clk),
    .we_i     (we),
    .waddr_i  (waddr),
    .wdata_i  (pc_i),
    .raddr0_i (wp_q - PW'(1)),
    .raddr1_i (wp_q - PW'(2)),
    .rdata0_o (rd_top),
    .rdata1_o (rd_next)
  );
  assign empty_o = cnt_q == '0;
  assign full_o  = cnt_q == CW'(DEPTH);
  // A replace on an empty stack degenerates to a plain push.
  always_comb begin
    op      = flush_i ? STK_FLUSH : (push_i && pop_i && !empty_o) ? STK_REPL :
              push_i ? STK_PUSH : pop_i ? STK_POP : STK_IDLE;
    do_push = op == STK_PUSH && (!full_o || OVF_WRAP);
    do_pop  = op == STK_POP && !empty_o;
    we      = cen && (do_push || op == STK_REPL);
    waddr   = op == STK_REPL ? wp_q - PW'(1) : wp_q;
    wp_d    = !cen ? wp_q : op == STK_FLUSH ? '0 : do_push ? wp_q + PW'(1) :
              do_pop ? wp_q - PW'(1) : wp_q;
    cnt_d   = !cen ? cnt_q : op == STK_FLUSH ? '0 : (do_push && !full_o) ? cnt_q + CW'(1) :
              do_pop ? cnt_q - CW'(1) : cnt_q;
    // Holding cycles re-read mem[wp-1], which always equals the registered top.
    top_d   = !cen ? top_q : op == STK_FLUSH ? '0 : (do_push || op == STK_REPL) ? pc_i :
              do_pop ? (cnt_q >= CW'(2) ? rd_next : '0) : empty_o ? '0 : rd_top;
    ovf_d   = !cen ? ovf_q : (ovf_q && !clr_err_i) || (op == STK_PUSH && full_o);
    unf_d   = !cen ? unf_q : (unf_q && !clr_err_i) || (op == STK_POP && empty_o);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp_q  <= '0;
      cnt_q <= '0;
      top_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      wp_q  <= wp_d;
      cnt_q <= cnt_d;
      top_q <= top_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end
  assign top_o   = top_q;
  assign count_o = cnt_q;
  assign ovf_o   = ovf_q;
  assign unf_o   = unf_q;
endmodule
